// File: rtl/slab_interval_sequencer_pkg.sv
// Shared definitions for the slab interval sequencer.
// - FloPoCo FP(11,6) word: [19:18] exception, [17] sign, [16:6] exponent, [5:0] fraction.
// - Exception codes, the +0 constant, FSM state encoding, comparator op ids and the tag format.
package slab_interval_sequencer_pkg;

  localparam int unsigned FpW = 20;

  localparam logic [1:0] ExcZero = 2'b00;
  localparam logic [1:0] ExcNorm = 2'b01;
  localparam logic [1:0] ExcInf  = 2'b10;
  localparam logic [1:0] ExcNan  = 2'b11;

  localparam logic [FpW-1:0] FpPosZero = '0;

  typedef enum logic [3:0] {
    StIdle,
    StIssue1A,
    StIssue1B,
    StWait1,
    StIssue2A,
    StIssue2B,
    StWait2,
    StIssue3A,
    StIssue3B,
    StWait3,
    StDone
  } state_e;

  // One id per comparator issue; OpNone marks an empty pipeline slot.
  typedef enum logic [2:0] {
    OpNone   = 3'd0,
    OpNearXy = 3'd1,  // max(tnear_x, tnear_y) -> m1
    OpFarXy  = 3'd2,  // min(tfar_x, tfar_y)   -> n1
    OpNearZ  = 3'd3,  // max(m1, tnear_z)      -> t_entry
    OpFarZ   = 3'd4,  // min(n1, tfar_z)       -> t_exit
    OpMiss   = 3'd5,  // t_entry > t_exit
    OpFront  = 3'd6   // t_exit > +0
  } op_e;

  typedef struct packed {
    logic valid;
    op_e  op;
  } tag_t;

endpackage

// File: rtl/slab_interval_sequencer_greater_than.sv
// greater_than: pipelined FP(11,6) comparator.
// - greater_o is 1 only when a_i - b_i would be a positive normal number: both operands
//   zero/normal and a_i strictly larger. Equal operands, inf and NaN give 0.
// - Result for operands presented in cycle c is valid during cycle c+Lat.
// Ports: clk, rst (async, active-high), a_i, b_i operands, greater_o result.
module greater_than
  import slab_interval_sequencer_pkg::*;
#(
  parameter int unsigned W   = 19,
  parameter int unsigned Lat = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [W:0] a_i,
  input  logic [W:0] b_i,
  output logic       greater_o
);

  logic           a_fin, b_fin, a_neg, b_neg, gt_d;
  logic [W-2:0]   a_key, b_key;
  logic [Lat-1:0] gt_q;

  always_comb begin
    a_fin = (a_i[W:W-1] != ExcInf) && (a_i[W:W-1] != ExcNan);
    b_fin = (b_i[W:W-1] != ExcInf) && (b_i[W:W-1] != ExcNan);
    a_neg = (a_i[W:W-1] == ExcNorm) && a_i[W-2];
    b_neg = (b_i[W:W-1] == ExcNorm) && b_i[W-2];
    // Magnitude key: zero sorts below every normal regardless of its exp/frac bits.
    a_key = (a_i[W:W-1] == ExcZero) ? '0 : {1'b1, a_i[W-3:0]};
    b_key = (b_i[W:W-1] == ExcZero) ? '0 : {1'b1, b_i[W-3:0]};
    gt_d  = 1'b0;
    if (a_fin && b_fin) begin
      unique case ({a_neg, b_neg})
        2'b00:   gt_d = a_key > b_key;
        2'b01:   gt_d = 1'b1;
        2'b10:   gt_d = 1'b0;
        default: gt_d = a_key < b_key;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_q <= '0;
    end else begin
      gt_q[0] <= gt_d;
      for (int unsigned i = 1; i < Lat; i++) begin
        gt_q[i] <= gt_q[i-1];
      end
    end
  end

  assign greater_o = gt_q[Lat-1];

endmodule

// File: rtl/slab_interval_sequencer.sv
// slab_interval_sequencer: closes a ray/AABB slab test with one shared greater_than.
// - Computes t_entry = max(tnear), t_exit = min(tfar), hit = !(t_entry > t_exit) && t_exit > +0.
// Ports: clk, rst (async, active-high); in_valid/in_ready input handshake with
// tnear_x/y/z, tfar_x/y/z; out_valid/out_ready output handshake with t_entry, t_exit, hit.
module slab_interval_sequencer
  import slab_interval_sequencer_pkg::*;
#(
  parameter int unsigned W       = 19,
  parameter int unsigned CMP_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [W:0] tnear_x,
  input  logic [W:0] tnear_y,
  input  logic [W:0] tnear_z,
  input  logic [W:0] tfar_x,
  input  logic [W:0] tfar_y,
  input  logic [W:0] tfar_z,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [W:0] t_entry,
  output logic [W:0] t_exit,
  output logic       hit
);

  state_e          state_q, state_d;
  op_e             issue_op, cap_op;
  tag_t            tag_q [CMP_LAT];
  tag_t            tag_out;
  logic [2:0][W:0] near_q, near_d, far_q, far_d;
  logic [W:0]      m1_q, m1_d, n1_q, n1_d;
  logic [W:0]      t_entry_q, t_entry_d, t_exit_q, t_exit_d;
  logic [W:0]      opa, opb;
  logic            miss_q, miss_d, hit_q, hit_d;
  logic            gt, accept;

  assign accept  = (state_q == StIdle) && in_valid;
  assign tag_out = tag_q[CMP_LAT-1];
  // Captures follow the tag alone, so stale comparator output is never consumed.
  assign cap_op  = tag_out.valid ? tag_out.op : OpNone;

  always_comb begin
    state_d  = state_q;
    issue_op = OpNone;
    case (state_q)
      StIdle:    if (in_valid) state_d = StIssue1A;
      StIssue1A: begin
        issue_op = OpNearXy;
        state_d  = StIssue1B;
      end
      StIssue1B: begin
        issue_op = OpFarXy;
        state_d  = (cap_op == OpNearXy) ? StIssue2A : StWait1;
      end
      StWait1:   if (cap_op == OpNearXy) state_d = StIssue2A;
      StIssue2A: begin
        issue_op = OpNearZ;
        state_d  = StIssue2B;
      end
      StIssue2B: begin
        issue_op = OpFarZ;
        state_d  = (cap_op == OpNearZ) ? StIssue3A : StWait2;
      end
      StWait2:   if (cap_op == OpNearZ) state_d = StIssue3A;
      StIssue3A: begin
        issue_op = OpMiss;
        state_d  = StIssue3B;
      end
      StIssue3B: begin
        issue_op = OpFront;
        state_d  = StWait3;
      end
      StWait3:   if (cap_op == OpFront) state_d = StDone;
      StDone:    if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Operand muxes keyed by the op being issued.
  always_comb begin
    opa = '0;
    opb = '0;
    case (issue_op)
      OpNearXy: begin
        opa = near_q[0];
        opb = near_q[1];
      end
      OpFarXy: begin
        opa = far_q[0];
        opb = far_q[1];
      end
      OpNearZ: begin
        opa = m1_q;
        opb = near_q[2];
      end
      OpFarZ: begin
        opa = n1_q;
        opb = far_q[2];
      end
      OpMiss: begin
        // t_exit resolves in this very cycle, so forward it instead of waiting a cycle.
        opa = t_entry_q;
        opb = t_exit_d;
      end
      OpFront: begin
        opa = t_exit_q;
        opb = (W+1)'(FpPosZero);
      end
      default: ;
    endcase
  end

  // Max keeps A only when A > B (ties go to B); min keeps A unless A > B.
  always_comb begin
    near_d    = accept ? {tnear_z, tnear_y, tnear_x} : near_q;
    far_d     = accept ? {tfar_z, tfar_y, tfar_x} : far_q;
    m1_d      = m1_q;
    n1_d      = n1_q;
    t_entry_d = t_entry_q;
    t_exit_d  = t_exit_q;
    miss_d    = miss_q;
    hit_d     = hit_q;
    case (cap_op)
      OpNearXy: m1_d      = gt ? near_q[0] : near_q[1];
      OpFarXy:  n1_d      = gt ? far_q[1] : far_q[0];
      OpNearZ:  t_entry_d = gt ? m1_q : near_q[2];
      OpFarZ:   t_exit_d  = gt ? far_q[2] : n1_q;
      OpMiss:   miss_d    = gt;
      OpFront:  hit_d     = !miss_q && gt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      near_q    <= '0;
      far_q     <= '0;
      m1_q      <= '0;
      n1_q      <= '0;
      t_entry_q <= '0;
      t_exit_q  <= '0;
      miss_q    <= 1'b0;
      hit_q     <= 1'b0;
      for (int unsigned i = 0; i < CMP_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      near_q    <= near_d;
      far_q     <= far_d;
      m1_q      <= m1_d;
      n1_q      <= n1_d;
      t_entry_q <= t_entry_d;
      t_exit_q  <= t_exit_d;
      miss_q    <= miss_d;
      hit_q     <= hit_d;
      tag_q[0]  <= '{valid: (issue_op != OpNone), op: issue_op};
      for (int unsigned i = 1; i < CMP_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  greater_than #(
    .W   (W),
    .Lat (CMP_LAT)
  ) u_greater_than (
    .clk       (clk),
    .rst       (rst),
    .a_i       (opa),
    .b_i       (opb),
    .greater_o (gt)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign t_entry   = t_entry_q;
  assign t_exit    = t_exit_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_slab_interval_sequencer.sv
// Bench: three sequencers (CMP_LAT = 4, 1, 7) share clock, reset and data inputs.
// A real-arithmetic model predicts handshake timing and results; a negedge process compares
// every cycle, and hand-computed literals pin first-result latency and values.
module tb_slab_interval_sequencer;
  localparam int unsigned W = 19;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid [3];
  logic       out_ready [3];
  logic       in_ready [3];
  logic       out_valid [3];
  logic       hit [3];
  logic [W:0] t_entry [3];
  logic [W:0] t_exit [3];
  logic [W:0] tnx, tny, tnz, tfx, tfy, tfz;

  always #5 clk = ~clk;

  slab_interval_sequencer #(.W(W), .CMP_LAT(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .tnear_x(tnx), .tnear_y(tny), .tnear_z(tnz), .tfar_x(tfx), .tfar_y(tfy), .tfar_z(tfz),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .t_entry(t_entry[0]),
    .t_exit(t_exit[0]), .hit(hit[0])
  );
  slab_interval_sequencer #(.W(W), .CMP_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .tnear_x(tnx), .tnear_y(tny), .tnear_z(tnz), .tfar_x(tfx), .tfar_y(tfy), .tfar_z(tfz),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .t_entry(t_entry[1]),
    .t_exit(t_exit[1]), .hit(hit[1])
  );
  slab_interval_sequencer #(.W(W), .CMP_LAT(7)) u_dut_l7 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .tnear_x(tnx), .tnear_y(tny), .tnear_z(tnz), .tfar_x(tfx), .tfar_y(tfy), .tfar_z(tfz),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .t_entry(t_entry[2]),
    .t_exit(t_exit[2]), .hit(hit[2])
  );

  function automatic int lat_of(input int k);
    if (k == 0) return 4;
    if (k == 1) return 1;
    return 7;
  endfunction

  function automatic int done_cyc(input int k);
    return 3 * lat_of(k) + 5;
  endfunction

  // Normal FP(11,6) word: (-1)^s * (1 + f/64) * 2^e
  function automatic logic [W:0] fpw(input bit s, input int e, input int f);
    logic [W:0] r;
    r = {2'b01, s, 11'(e + 1023), 6'(f)};
    return r;
  endfunction

  function automatic real fp_val(input logic [W:0] v);
    real r;
    int  e;
    if (v[W:W-1] == 2'b00) return 0.0;
    r = 1.0 + real'(v[5:0]) / 64.0;
    e = int'(v[W-3:6]) - 1023;
    for (int i = 0; i < e; i++) r = r * 2.0;
    for (int i = 0; i > e; i--) r = r / 2.0;
    if (v[W-2]) r = -r;
    return r;
  endfunction

  // A > B only when the difference is a finite, positive, nonzero number.
  function automatic bit m_gt(input logic [W:0] a, input logic [W:0] b);
    if (a[W] || b[W]) return 1'b0;
    return fp_val(a) > fp_val(b);
  endfunction

  function automatic logic [W:0] m_max(input logic [W:0] a, input logic [W:0] b);
    return m_gt(a, b) ? a : b;
  endfunction

  function automatic logic [W:0] m_min(input logic [W:0] a, input logic [W:0] b);
    return m_gt(a, b) ? b : a;
  endfunction

  // Behavioural model: accept, count cycles, results ready 3L+5 cycles after accept.
  bit         m_busy [3];
  int         m_cnt [3];
  logic [W:0] m_entry [3];
  logic [W:0] m_exit [3];
  bit         m_hit [3];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0;
        m_cnt[k]  <= 0;
      end else if (m_busy[k]) begin
        if (m_cnt[k] >= done_cyc(k) && out_ready[k]) m_busy[k] <= 1'b0;
        m_cnt[k] <= m_cnt[k] + 1;
      end else if (in_valid[k]) begin
        m_busy[k]  <= 1'b1;
        m_cnt[k]   <= 1;
        m_entry[k] <= m_max(m_max(tnx, tny), tnz);
        m_exit[k]  <= m_min(m_min(tfx, tfy), tfz);
        m_hit[k]   <= !m_gt(m_max(m_max(tnx, tny), tnz), m_min(m_min(tfx, tfy), tfz)) &&
                      m_gt(m_min(m_min(tfx, tfy), tfz), '0);
      end
    end
  end

  // Requests from the stimulus process; the compare process acknowledges them.
  int         checks = 0;
  int         failures = 0;
  int         rst_req = 0;
  int         rst_done = 0;
  int         lit_req [3];
  int         lit_done [3];
  int         lit_lat [3];
  logic [W:0] lit_entry [3];
  logic [W:0] lit_exit [3];
  bit         lit_hit [3];
  bit         prev_ov [3];

  task automatic check(input string nm, input int k, input logic [W:0] act,
                       input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  initial begin : compare
    bit exp_ov;
    for (int k = 0; k < 3; k++) begin
      lit_done[k] = 0;
      prev_ov[k]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_ov = m_busy[k] && (m_cnt[k] >= done_cyc(k));
        check("in_ready", k, in_ready[k], !m_busy[k]);
        check("out_valid", k, out_valid[k], exp_ov);
        if (exp_ov) begin
          check("t_entry", k, t_entry[k], m_entry[k]);
          check("t_exit", k, t_exit[k], m_exit[k]);
          check("hit", k, hit[k], m_hit[k]);
        end
        if (lit_req[k] != lit_done[k] && out_valid[k] && !prev_ov[k]) begin
          check("lit_latency", k, m_cnt[k], lit_lat[k]);
          check("lit_t_entry", k, t_entry[k], lit_entry[k]);
          check("lit_t_exit", k, t_exit[k], lit_exit[k]);
          check("lit_hit", k, hit[k], lit_hit[k]);
          lit_done[k] = lit_req[k];
        end
        prev_ov[k] = out_valid[k];
      end
      if (rst_req != rst_done) begin
        for (int k = 0; k < 3; k++) begin
          check("rst_out_valid", k, out_valid[k], 0);
          check("rst_in_ready", k, in_ready[k], 1);
          check("rst_t_entry", k, t_entry[k], 0);
          check("rst_t_exit", k, t_exit[k], 0);
          check("rst_hit", k, hit[k], 0);
        end
        rst_done = rst_req;
      end
    end
  end

  task automatic drive(input logic [W:0] a, input logic [W:0] b, input logic [W:0] c,
                       input logic [W:0] d, input logic [W:0] e, input logic [W:0] f);
    tnx = a; tny = b; tnz = c; tfx = d; tfy = e; tfz = f;
  endtask

  task automatic arm(input int k, input logic [W:0] ee, input logic [W:0] ex, input bit eh);
    lit_entry[k] = ee;
    lit_exit[k]  = ex;
    lit_hit[k]   = eh;
    lit_lat[k]   = done_cyc(k);
    lit_req[k]   = lit_req[k] + 1;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 300 && m_busy[k]; i++) @(negedge clk);
  endtask

  task automatic start(input int k);
    in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  logic [W:0] f1, f2, f3, f4, f6, f8, f9, fh, n1, n2, n3, n5, n6, n7;

  initial begin : stim
    f1 = fpw(0, 0, 0);  f2 = fpw(0, 1, 0);  f3 = fpw(0, 1, 32); f4 = fpw(0, 2, 0);
    f6 = fpw(0, 2, 32); f8 = fpw(0, 3, 0);  f9 = fpw(0, 3, 8);  fh = fpw(0, -1, 0);
    n1 = fpw(1, 0, 0);  n2 = fpw(1, 1, 0);  n3 = fpw(1, 1, 32); n5 = fpw(1, 2, 16);
    n6 = fpw(1, 2, 32); n7 = fpw(1, 2, 48);
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      lit_req[k]   = 0;
    end
    drive('0, '0, '0, '0, '0, '0);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst_req = rst_req + 1;
    @(negedge clk);

    // CMP_LAT = 4 directed cases
    drive(f1, f2, fh, f8, f4, f6); arm(0, f2, f4, 1'b1); start(0); wait_idle(0);
    drive(f3, f1, f1, f2, f9, f9); arm(0, f3, f2, 1'b0); start(0); wait_idle(0);
    drive(n5, n6, n7, n1, n2, n3); arm(0, n5, n3, 1'b0); start(0); wait_idle(0);
    drive(f2, f2, f2, f2, f2, f2); arm(0, f2, f2, 1'b1); start(0); wait_idle(0);

    // Backpressure: results held 5 cycles, busy-time in_valid ignored, next accept right after
    out_ready[0] = 1'b0;
    drive(n5, n6, n7, n1, n2, n3); arm(0, n5, n3, 1'b0); start(0);
    for (int i = 0; i < 100 && m_cnt[0] < done_cyc(0); i++) @(negedge clk);
    drive(f3, f1, f1, f2, f9, f9);
    in_valid[0] = 1'b1;
    repeat (5) @(negedge clk);
    drive(f1, f2, fh, f8, f4, f6); arm(0, f2, f4, 1'b1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_idle(0);
    @(negedge clk);

    // Reset pulse in cycle 8 of an operation, then a clean case-1 run
    drive(f3, f1, f1, f2, f9, f9); start(0);
    for (int i = 0; i < 50 && m_cnt[0] < 8; i++) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rst_req = rst_req + 1;
    @(negedge clk);
    drive(f1, f2, fh, f8, f4, f6); arm(0, f2, f4, 1'b1); start(0); wait_idle(0);

    // Cases 1-2 at CMP_LAT = 1 and 7
    for (int k = 1; k < 3; k++) begin
      drive(f1, f2, fh, f8, f4, f6); arm(k, f2, f4, 1'b1); start(k); wait_idle(k);
      drive(f3, f1, f1, f2, f9, f9); arm(k, f3, f2, 1'b0); start(k); wait_idle(k);
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (lit_req[k] != lit_done[k]) begin
        failures++;
        $display("FAIL lit_pending dut%0d: got %0d results, expected %0d", k, lit_done[k],
                 lit_req[k]);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
